// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer and its lane aligner.
package lsu_pkg;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} lsu_state_e;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   localparam int BE_W = 4;

   // Encodings without a defined size fall back to a full word.
   function automatic lsu_size_e size_of(input logic [2:0] f3);
      case (f3)
         LS_B, LS_BU: size_of = SZ_B;
         LS_H, LS_HU: size_of = SZ_H;
         default:     size_of = SZ_W;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (size_of(f3))
         SZ_H:    misaligned = a[0];
         SZ_W:    misaligned = |a;
         default: misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extract/extend.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_fun3,
   input  logic [1:0]      i_addr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [XLEN-1:0] i_rdata,
   output logic [BE_W-1:0] o_be,
   output logic [XLEN-1:0] o_wdata,
   output logic [XLEN-1:0] o_rdata
);

   lsu_size_e   w_size;
   logic        w_signed;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_size   = size_of(i_fun3);
   assign w_signed = ~i_fun3[2];
   // Misaligned halves fall back to addr[1] alone; words always use lane 0.
   assign w_half   = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      o_rdata = i_rdata;
      case (w_size)
         SZ_B: begin
            o_be    = 4'b0001 << i_addr;
            o_wdata = {(XLEN/8){i_wdata[7:0]}};
            o_rdata = w_signed ? {{(XLEN-8){w_byte[7]}}, w_byte}
                               : {{(XLEN-8){1'b0}}, w_byte};
         end
         SZ_H: begin
            o_be    = 4'b0011 << {i_addr[1], 1'b0};
            o_wdata = {(XLEN/16){i_wdata[15:0]}};
            o_rdata = w_signed ? {{(XLEN-16){w_half[15]}}, w_half}
                               : {{(XLEN-16){1'b0}}, w_half};
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer between core decode and a req/gnt/rvalid memory port.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module lsu_sequencer
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            store_i,
   input  logic [2:0]      fun3_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [BE_W-1:0] mem_be_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   lsu_state_e      r_state, w_next;
   logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
   logic [2:0]      r_fun3;
   logic            r_we;
   logic [7:0]      r_cnt;

   logic            w_start, w_trap, w_timeout, w_cnt_clr;
   logic            w_stall, w_done, w_err, w_req;
   logic [BE_W-1:0] w_be;
   logic [XLEN-1:0] w_wdata, w_ldata;

   assign w_start   = load_i | store_i;
   assign w_timeout = (r_cnt == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
   assign w_trap = misaligned(fun3_i, addr_i[1:0]);
`else
   assign w_trap = 1'b0;
`endif

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_fun3  (r_fun3),
      .i_addr  (r_addr[1:0]),
      .i_wdata (r_wdata),
      .i_rdata (mem_rdata_i),
      .o_be    (w_be),
      .o_wdata (w_wdata),
      .o_rdata (w_ldata)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // The awaited handshake is checked before the timeout so a late grant/rvalid still wins.
   always_comb begin
      w_next    = r_state;
      w_cnt_clr = 1'b0;
      w_stall   = 1'b0;
      w_done    = 1'b0;
      w_err     = 1'b0;
      w_req     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_stall = 1'b1;
               if (w_trap) begin
                  w_next = ERR;
               end else begin
                  w_next    = REQ;
                  w_cnt_clr = 1'b1;
               end
            end
         end
         REQ: begin
            w_stall = 1'b1;
            w_req   = 1'b1;
            if (mem_gnt_i) begin
               w_next    = r_we ? DONE : WAIT;
               w_cnt_clr = 1'b1;
            end else if (w_timeout) begin
               w_next = ERR;
            end
         end
         WAIT: begin
            w_stall = 1'b1;
            if (mem_rvalid_i)   w_next = DONE;
            else if (w_timeout) w_next = ERR;
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         ERR: begin
            w_err  = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_fun3  <= '0;
         r_we    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (r_state == IDLE && w_start) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_fun3  <= fun3_i;
            r_we    <= store_i & ~load_i;
         end
         if (w_cnt_clr)
            r_cnt <= '0;
         else if (r_state == REQ || r_state == WAIT)
            r_cnt <= r_cnt + 8'd1;
         if (r_state == WAIT && mem_rvalid_i)
            r_rdata <= w_ldata;
      end
   end

   assign stall_o     = w_stall;
   assign done_o      = w_done;
   assign err_o       = w_err;
   assign rdata_o     = (w_done && !r_we) ? r_rdata : '0;
   assign mem_req_o   = w_req;
   assign mem_we_o    = w_req & r_we;
   assign mem_addr_o  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
   assign mem_be_o    = w_req ? w_be : '0;
   assign mem_wdata_o = w_req ? w_wdata : '0;

endmodule
